// File: rtl/mp_pkg.sv
// Shared types and constants for the mixed-precision operand sequencer.
// The weight-width encoding here is the one used on the in_mode_i input.
package mp_pkg;

    localparam int NUM_LANES = 2;
    localparam int HALF_W    = 16;
    localparam int WORD_W    = 32;

    typedef enum logic [1:0] {
        PREC_RSVD = 2'b00,
        PREC_8    = 2'b01,
        PREC_4    = 2'b10,
        PREC_2    = 2'b11
    } prec_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_e;

    function automatic logic [2:0] beats_for(input prec_mode_e mode);
        logic [2:0] n;
        case (mode)
            PREC_8:  n = 3'd1;
            PREC_4:  n = 3'd2;
            PREC_2:  n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Two's-complement extension of a B-bit weight held in the low bits of raw.
    function automatic logic [HALF_W-1:0] sext_weight(input logic [7:0] raw, input prec_mode_e mode);
        logic [HALF_W-1:0] w;
        case (mode)
            PREC_8:  w = {{8{raw[7]}}, raw};
            PREC_4:  w = {{12{raw[3]}}, raw[3:0]};
            PREC_2:  w = {{14{raw[1]}}, raw[1:0]};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mp_lane_extract.sv
// Combinational slicer: picks the four weights of beat k out of a packed word
// and sign-extends them into two lanes of {w[odd], w[even]}.
module mp_lane_extract
    import mp_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  prec_mode_e        mode_i,
    input  logic [1:0]        beat_i,
    output logic [WORD_W-1:0] op_o [NUM_LANES]
);

    logic [HALF_W-1:0] w_s [4];

    // Weight index 4k+i; indices past the end of the word read as zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [3:0]        idx;
            logic [4:0]        base;
            logic              present;
            logic [WORD_W-1:0] shifted;
            idx = {beat_i, 2'(i)};
            case (mode_i)
                PREC_8: begin
                    present = (idx < 4'd4);
                    base    = {idx[1:0], 3'b000};
                end
                PREC_4: begin
                    present = (idx < 4'd8);
                    base    = {idx[2:0], 2'b00};
                end
                PREC_2: begin
                    present = 1'b1;
                    base    = {idx, 1'b0};
                end
                default: begin
                    present = 1'b0;
                    base    = 5'd0;
                end
            endcase
            shifted = word_i >> base;
            if (present) begin
                w_s[i] = sext_weight(shifted[7:0], mode_i);
            end else begin
                w_s[i] = 16'h0000;
            end
        end
    end

    assign op_o[0] = {w_s[1], w_s[0]};
    assign op_o[1] = {w_s[3], w_s[2]};

endmodule

// File: rtl/mp_operand_sequencer.sv
// Accepts one packed weight word and issues it as 1, 2 or 4 registered beats
// of two sign-extended operand lanes, with valid/ready on both sides.
module mp_operand_sequencer
    import mp_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_word_i,
    input  logic [1:0]        in_mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] op_o [NUM_LANES],
    output logic [1:0]        beat_o,
    output logic              last_o,
    output logic              pack_mode_o,
    output logic              err_o
);

    seq_state_e        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    prec_mode_e        mode_q, mode_d;
    logic [1:0]        beat_q, beat_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] op_q [NUM_LANES];
    logic [WORD_W-1:0] op_d [NUM_LANES];
    logic              last_q, last_d;
    logic              pack_q, pack_d;
    logic              err_q, err_d;

    prec_mode_e        in_mode_s;
    logic              accept_s, consume_s, legal_s;
    logic              load_s, step_s, clear_s;
    logic [WORD_W-1:0] ext_word_s;
    prec_mode_e        ext_mode_s;
    logic [1:0]        ext_beat_s;
    logic [WORD_W-1:0] ext_op_s [NUM_LANES];
    logic              next_last_s;

    assign in_mode_s  = prec_mode_e'(in_mode_i);
    assign in_ready_o = ((state_q == ST_IDLE) | (out_valid_q & last_q & out_ready_i)) & ~flush_i;
    assign accept_s   = in_valid_i & in_ready_o;
    assign consume_s  = out_valid_q & out_ready_i;
    assign legal_s    = (in_mode_s != PREC_RSVD);

    assign load_s  = accept_s & legal_s;
    assign step_s  = ~flush_i & ~accept_s & consume_s & ~last_q;
    assign clear_s = flush_i | (accept_s & ~legal_s) | (~accept_s & consume_s & last_q);

    // The extractor always looks at the beat that will be presented next.
    assign ext_word_s  = accept_s ? in_word_i : word_q;
    assign ext_mode_s  = accept_s ? in_mode_s : mode_q;
    assign ext_beat_s  = accept_s ? 2'd0 : (beat_q + 2'd1);
    assign next_last_s = ({1'b0, ext_beat_s} == (beats_for(ext_mode_s) - 3'd1));

    mp_lane_extract u_extract (
        .word_i (ext_word_s),
        .mode_i (ext_mode_s),
        .beat_i (ext_beat_s),
        .op_o   (ext_op_s)
    );

    // Next-state: load a new word, advance a beat, drop back to idle, or hold.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        mode_d      = mode_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        pack_d      = pack_q;
        err_d       = 1'b0;
        for (int j = 0; j < NUM_LANES; j++) begin
            op_d[j] = op_q[j];
        end
        if (load_s) begin
            state_d     = ST_ISSUE;
            word_d      = in_word_i;
            mode_d      = in_mode_s;
            beat_d      = 2'd0;
            out_valid_d = 1'b1;
            last_d      = next_last_s;
            pack_d      = (in_mode_s == PREC_2);
            for (int j = 0; j < NUM_LANES; j++) begin
                op_d[j] = ext_op_s[j];
            end
        end else if (step_s) begin
            beat_d = ext_beat_s;
            last_d = next_last_s;
            for (int j = 0; j < NUM_LANES; j++) begin
                op_d[j] = ext_op_s[j];
            end
        end else if (clear_s) begin
            state_d     = ST_IDLE;
            word_d      = 32'h0000_0000;
            mode_d      = PREC_RSVD;
            beat_d      = 2'd0;
            out_valid_d = 1'b0;
            last_d      = 1'b0;
            pack_d      = 1'b0;
            err_d       = accept_s & ~legal_s & ~flush_i;
            for (int j = 0; j < NUM_LANES; j++) begin
                op_d[j] = 32'h0000_0000;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            word_q      <= 32'h0000_0000;
            mode_q      <= PREC_RSVD;
            beat_q      <= 2'd0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            pack_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int j = 0; j < NUM_LANES; j++) begin
                op_q[j] <= 32'h0000_0000;
            end
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            mode_q      <= mode_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            pack_q      <= pack_d;
            err_q       <= err_d;
            for (int j = 0; j < NUM_LANES; j++) begin
                op_q[j] <= op_d[j];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign beat_o      = beat_q;
    assign last_o      = last_q;
    assign pack_mode_o = pack_q;
    assign err_o       = err_q;
    assign op_o[0]     = op_q[0];
    assign op_o[1]     = op_q[1];

endmodule

// File: tb/tb_mp_operand_sequencer.sv
// Directed bench for mp_operand_sequencer: a vector table of whole words plus
// hand-written backpressure, back-to-back, flush, reserved-mode and reset sequences.
module tb_mp_operand_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_word_i = 32'h0;
    logic [1:0]  in_mode_i = 2'b00;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] op_o [2];
    logic [1:0]  beat_o;
    logic        last_o;
    logic        pack_mode_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]        mode;
        logic [31:0]       word;
        int                nbeats;
        logic [3:0][31:0]  op0;
        logic [3:0][31:0]  op1;
        logic              pack;
    } vec_t;

    vec_t vecs [6];

    mp_operand_sequencer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_word_i   (in_word_i),
        .in_mode_i   (in_mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .op_o        (op_o),
        .beat_o      (beat_o),
        .last_o      (last_o),
        .pack_mode_o (pack_mode_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one word with out_ready high; returns one cycle after the accept edge.
    task automatic present(input logic [1:0] mode, input logic [31:0] word, input string name);
        in_valid_i = 1'b1;
        in_word_i  = word;
        in_mode_i  = mode;
        #1;
        chk({name, " in_ready"}, {31'b0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0;
        in_word_i  = 32'hDEAD_BEEF;
        in_mode_i  = 2'b00;
    endtask

    task automatic chk_beat(input string name, input int b, input logic [31:0] e0,
                            input logic [31:0] e1, input logic elast, input logic epack);
        chk($sformatf("%s b%0d valid", name, b), {31'b0, out_valid_o}, 32'd1);
        chk($sformatf("%s b%0d beat", name, b), {30'b0, beat_o}, b[31:0]);
        chk($sformatf("%s b%0d op0", name, b), op_o[0], e0);
        chk($sformatf("%s b%0d op1", name, b), op_o[1], e1);
        chk($sformatf("%s b%0d last", name, b), {31'b0, last_o}, {31'b0, elast});
        chk($sformatf("%s b%0d pack", name, b), {31'b0, pack_mode_o}, {31'b0, epack});
    endtask

    initial begin
        vecs[0] = '{2'b01, 32'h807F01FF, 1, {96'h0, 32'h0001FFFF}, {96'h0, 32'hFF80007F}, 1'b0};
        vecs[1] = '{2'b10, 32'h00008F71, 2, {96'h0, 32'h00070001}, {96'h0, 32'hFFF8FFFF}, 1'b0};
        vecs[2] = '{2'b11, 32'hE4E4E4E4, 4, {4{32'h00010000}}, {4{32'hFFFFFFFE}}, 1'b1};
        vecs[3] = '{2'b10, 32'h12345678, 2, {64'h0, 32'h00030004, 32'h0007FFF8},
                    {64'h0, 32'h00010002, 32'h00050006}, 1'b0};
        vecs[4] = '{2'b11, 32'hFFAA5500, 4,
                    {32'hFFFFFFFF, 32'hFFFEFFFE, 32'h00010001, 32'h00000000},
                    {32'hFFFFFFFF, 32'hFFFEFFFE, 32'h00010001, 32'h00000000}, 1'b1};
        vecs[5] = '{2'b01, 32'h7F80FF00, 1, {96'h0, 32'hFFFF0000}, {96'h0, 32'h007FFF80}, 1'b0};

        // Reset values
        #2;
        chk("rst valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst op0", op_o[0], 32'd0);
        chk("rst op1", op_o[1], 32'd0);
        chk("rst beat", {30'b0, beat_o}, 32'd0);
        chk("rst last", {31'b0, last_o}, 32'd0);
        chk("rst pack", {31'b0, pack_mode_o}, 32'd0);
        chk("rst err", {31'b0, err_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("rst in_ready", {31'b0, in_ready_o}, 32'd1);

        // Table-driven words
        for (int v = 0; v < 6; v++) begin
            present(vecs[v].mode, vecs[v].word, $sformatf("vec%0d", v));
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                chk_beat($sformatf("vec%0d", v), b, vecs[v].op0[b], vecs[v].op1[b],
                         (b == vecs[v].nbeats - 1), vecs[v].pack);
                tick();
            end
            chk($sformatf("vec%0d idle valid", v), {31'b0, out_valid_o}, 32'd0);
            chk($sformatf("vec%0d idle ready", v), {31'b0, in_ready_o}, 32'd1);
        end

        // Backpressure on beat 1 of a 2-bit word
        present(2'b11, 32'hFFAA5500, "bp");
        chk_beat("bp", 0, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
        tick();
        chk_beat("bp", 1, 32'h00010001, 32'h00010001, 1'b0, 1'b1);
        out_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_beat($sformatf("bp hold%0d", c), 1, 32'h00010001, 32'h00010001, 1'b0, 1'b1);
            chk($sformatf("bp hold%0d ready", c), {31'b0, in_ready_o}, 32'd0);
        end
        out_ready_i = 1'b1;
        tick();
        chk_beat("bp", 2, 32'hFFFEFFFE, 32'hFFFEFFFE, 1'b0, 1'b1);
        tick();
        chk_beat("bp", 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        tick();
        chk("bp end valid", {31'b0, out_valid_o}, 32'd0);

        // Back-to-back: next word offered while the last beat is consumed
        present(2'b01, 32'h807F01FF, "b2b a");
        chk_beat("b2b a", 0, 32'h0001FFFF, 32'hFF80007F, 1'b1, 1'b0);
        in_valid_i = 1'b1;
        in_word_i  = 32'h00008F71;
        in_mode_i  = 2'b10;
        #1;
        chk("b2b in_ready", {31'b0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0;
        in_mode_i  = 2'b00;
        chk_beat("b2b b", 0, 32'h00070001, 32'hFFF8FFFF, 1'b0, 1'b0);
        tick();
        chk_beat("b2b b", 1, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
        tick();
        chk("b2b end valid", {31'b0, out_valid_o}, 32'd0);

        // Flush at beat 2, with a competing word offered in the same cycle
        present(2'b11, 32'hFFAA5500, "fl");
        tick();
        tick();
        chk_beat("fl", 2, 32'hFFFEFFFE, 32'hFFFEFFFE, 1'b0, 1'b1);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_word_i  = 32'h807F01FF;
        in_mode_i  = 2'b01;
        #1;
        chk("fl in_ready low", {31'b0, in_ready_o}, 32'd0);
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        in_mode_i  = 2'b00;
        #1;
        chk("fl valid", {31'b0, out_valid_o}, 32'd0);
        chk("fl in_ready", {31'b0, in_ready_o}, 32'd1);
        tick();
        chk("fl no accept", {31'b0, out_valid_o}, 32'd0);

        // Reserved mode: single err pulse, no beats
        present(2'b00, 32'h12345678, "rsvd");
        chk("rsvd err", {31'b0, err_o}, 32'd1);
        chk("rsvd valid", {31'b0, out_valid_o}, 32'd0);
        chk("rsvd in_ready", {31'b0, in_ready_o}, 32'd1);
        tick();
        chk("rsvd err drop", {31'b0, err_o}, 32'd0);
        chk("rsvd valid2", {31'b0, out_valid_o}, 32'd0);

        // Asynchronous reset mid-word
        present(2'b11, 32'hE4E4E4E4, "mr");
        tick();
        chk_beat("mr", 1, 32'h00010000, 32'hFFFFFFFE, 1'b0, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mr valid", {31'b0, out_valid_o}, 32'd0);
        chk("mr op0", op_o[0], 32'd0);
        chk("mr op1", op_o[1], 32'd0);
        chk("mr pack", {31'b0, pack_mode_o}, 32'd0);
        chk("mr beat", {30'b0, beat_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("mr rel valid", {31'b0, out_valid_o}, 32'd0);
        chk("mr rel ready", {31'b0, in_ready_o}, 32'd1);
        chk("mr rel last", {31'b0, last_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
